// File: rtl/obstacle_generator_if.sv
// Obstacle generator bus: control pulses in, block geometry and game status out.
//   start, frame_tick, collision : control inputs to the generator
//   block_x/y/width/height       : current block geometry
//   block_valid                  : geometry is meaningful (block on screen)
//   score, speed, game_over      : game status
interface obstacle_generator_if;
    logic       start;
    logic       frame_tick;
    logic       collision;
    logic [7:0] block_x;
    logic [6:0] block_y;
    logic [3:0] block_width;
    logic [3:0] block_height;
    logic       block_valid;
    logic [7:0] score;
    logic [2:0] speed;
    logic       game_over;

    // Driver of control pulses / consumer of geometry
    modport master (
        output start, frame_tick, collision,
        input  block_x, block_y, block_width, block_height,
        input  block_valid, score, speed, game_over
    );

    // The generator itself
    modport slave (
        input  start, frame_tick, collision,
        output block_x, block_y, block_width, block_height,
        output block_valid, score, speed, game_over
    );
endinterface

// File: rtl/obstacle_generator.sv
// Obstacle generator: spawns a pseudo-random block at the right screen edge,
// scrolls it left once per frame, waits a random gap after it exits, and
// freezes on collision until restarted.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : obstacle_generator_if.slave (start/frame_tick/collision in,
//           geometry, score, speed and game_over out; all registered)
module obstacle_generator #(
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned GROUND_Y   = 100,
    parameter int unsigned MIN_W      = 4,
    parameter int unsigned MIN_H      = 4,
    parameter int unsigned MIN_GAP    = 8,
    parameter int unsigned BASE_SPEED = 1,
    parameter int unsigned MAX_SPEED  = 4,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    obstacle_generator_if.slave  bus
);

    localparam int unsigned GAP_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GAP    = 2'd1,
        S_SCROLL = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_lfsr;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] r_next_gap;
    logic [7:0]       r_block_x;
    logic [6:0]       r_block_y;
    logic [3:0]       r_block_w;
    logic [3:0]       r_block_h;
    logic             r_block_valid;
    logic [7:0]       r_score;
    logic [2:0]       r_speed;
    logic             r_game_over;

    logic [7:0]       w_lfsr_next;
    logic [3:0]       w_spawn_w;
    logic [3:0]       w_spawn_h;
    logic [6:0]       w_spawn_y;
    logic [GAP_W-1:0] w_spawn_gap;
    logic [7:0]       w_score_inc;
    logic             w_speed_up;
    logic             w_can_move;
    logic             w_restart;

    // Spawn geometry and next gap come from the current (pre-advance) LFSR value
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_spawn_w   = 4'(MIN_W) + {1'b0, r_lfsr[1:0], 1'b0};
    assign w_spawn_h   = 4'(MIN_H) + {1'b0, r_lfsr[4:2]};
    assign w_spawn_y   = 7'(GROUND_Y) - {3'b000, w_spawn_h};
    assign w_spawn_gap = GAP_W'(MIN_GAP) + {1'b0, r_lfsr[7:5], 2'b00};

    // Score saturates; speed steps up when the new score hits a multiple of 8
    assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_speed_up  = (w_score_inc[2:0] == 3'd0) && (w_score_inc != 8'd0)
                       && (r_speed < 3'(MAX_SPEED));

    // Exit is taken instead of a subtraction that would underflow
    assign w_can_move  = (r_block_x >= {5'b00000, r_speed});

    assign w_restart   = bus.start && ((r_state == S_IDLE) || (r_state == S_HALT));

    // Game FSM and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_gap_cnt     <= '0;
            r_next_gap    <= '0;
            r_block_x     <= '0;
            r_block_y     <= '0;
            r_block_w     <= '0;
            r_block_h     <= '0;
            r_block_valid <= 1'b0;
            r_score       <= '0;
            r_speed       <= 3'(BASE_SPEED);
            r_game_over   <= 1'b0;
        end else if (w_restart) begin
            // start beats a same-cycle frame_tick; geometry is left as-is
            r_state       <= S_GAP;
            r_lfsr        <= LFSR_SEED;
            r_gap_cnt     <= '0;
            r_block_valid <= 1'b0;
            r_score       <= '0;
            r_speed       <= 3'(BASE_SPEED);
            r_game_over   <= 1'b0;
        end else begin
            unique case (r_state)
                S_GAP: begin
                    if (bus.frame_tick) begin
                        r_lfsr <= w_lfsr_next;
                        if (r_gap_cnt == '0) begin
                            r_block_x     <= 8'(SCREEN_W - 1);
                            r_block_y     <= w_spawn_y;
                            r_block_w     <= w_spawn_w;
                            r_block_h     <= w_spawn_h;
                            r_next_gap    <= w_spawn_gap;
                            r_block_valid <= 1'b1;
                            r_state       <= S_SCROLL;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        end
                    end
                end
                S_SCROLL: begin
                    // Collision pre-empts movement and LFSR advance
                    if (bus.collision && r_block_valid) begin
                        r_state     <= S_HALT;
                        r_game_over <= 1'b1;
                    end else if (bus.frame_tick) begin
                        r_lfsr <= w_lfsr_next;
                        if (w_can_move) begin
                            r_block_x <= r_block_x - {5'b00000, r_speed};
                        end else begin
                            r_block_valid <= 1'b0;
                            r_score       <= w_score_inc;
                            r_gap_cnt     <= r_next_gap;
                            r_state       <= S_GAP;
                            if (w_speed_up) begin
                                r_speed <= r_speed + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and HALT hold everything until start
                end
            endcase
        end
    end

    assign bus.block_x      = r_block_x;
    assign bus.block_y      = r_block_y;
    assign bus.block_width  = r_block_w;
    assign bus.block_height = r_block_h;
    assign bus.block_valid  = r_block_valid;
    assign bus.score        = r_score;
    assign bus.speed        = r_speed;
    assign bus.game_over    = r_game_over;

endmodule

// File: tb/tb_obstacle_generator.sv
// Bench for obstacle_generator: directed stimulus, a frame-level game model,
// a per-cycle compare process and hand-computed literal checkpoints.
module tb_obstacle_generator;

    localparam int M_IDLE   = 0;
    localparam int M_GAP    = 1;
    localparam int M_SCROLL = 2;
    localparam int M_HALT   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obstacle_generator_if bus ();

    obstacle_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Game model state
    int m_state, m_lfsr, m_gap, m_stored;
    int m_x, m_y, m_w, m_h, m_valid, m_score, m_speed, m_go;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Shift left, feedback = parity of taps 7,5,4,3
    function automatic int lfsr_step(input int l);
        return ((l << 1) & 255) | ($countones(l & 'hB8) & 1);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_lfsr = 'hA5; m_gap = 0; m_stored = 0;
        m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_valid = 0;
        m_score = 0; m_speed = 1; m_go = 0;
    endtask

    task automatic model_clock(input bit s, input bit t, input bit c);
        if (s && (m_state == M_IDLE || m_state == M_HALT)) begin
            m_state = M_GAP; m_gap = 0; m_score = 0; m_speed = 1;
            m_lfsr = 'hA5; m_valid = 0; m_go = 0;
        end else if (c && m_state == M_SCROLL) begin
            m_state = M_HALT; m_go = 1;
        end else if (t && m_state == M_GAP) begin
            if (m_gap == 0) begin
                m_w = 4 + 2 * (m_lfsr % 4);
                m_h = 4 + (m_lfsr / 4) % 8;
                m_x = 159;
                m_y = 100 - m_h;
                m_stored = 8 + 4 * (m_lfsr / 32);
                m_valid = 1;
                m_state = M_SCROLL;
            end else begin
                m_gap = m_gap - 1;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end else if (t && m_state == M_SCROLL) begin
            if (m_x - m_speed >= 0) begin
                m_x = m_x - m_speed;
            end else begin
                m_valid = 0;
                if (m_score < 255) m_score = m_score + 1;
                if (m_score % 8 == 0 && m_speed < 4) m_speed = m_speed + 1;
                m_gap = m_stored;
                m_state = M_GAP;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("block_x",      int'(bus.block_x),      m_x);
            check("block_y",      int'(bus.block_y),      m_y);
            check("block_width",  int'(bus.block_width),  m_w);
            check("block_height", int'(bus.block_height), m_h);
            check("block_valid",  int'(bus.block_valid),  m_valid);
            check("score",        int'(bus.score),        m_score);
            check("speed",        int'(bus.speed),        m_speed);
            check("game_over",    int'(bus.game_over),    m_go);
        end
    end

    // One clock with the given inputs; returns just after the falling edge
    task automatic step(input bit s, input bit t, input bit c);
        bus.start = s; bus.frame_tick = t; bus.collision = c;
        @(posedge clk);
        if (reset) model_reset();
        else model_clock(s, t, c);
        #1;
        bus.start = 1'b0; bus.frame_tick = 1'b0; bus.collision = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_to_score(input int target);
        int budget;
        budget = 20000;
        while (m_score < target && budget > 0) begin
            step(1'b0, 1'b1, 1'b0);
            budget--;
        end
        check("run_to_score_timeout", m_score, target);
    endtask

    task automatic run_to_scroll();
        int budget;
        budget = 100;
        while (m_state != M_SCROLL && budget > 0) begin
            step(1'b0, 1'b1, 1'b0);
            budget--;
        end
        check("run_to_scroll_timeout", m_state, M_SCROLL);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.frame_tick = 1'b0; bus.collision = 1'b0;
        model_reset();
        @(negedge clk); #1;
        chk_en = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        check("rst_speed", int'(bus.speed), 1);
        check("rst_valid", int'(bus.block_valid), 0);

        // IDLE ignores ticks; start beats a same-cycle tick
        step(0, 1, 0);
        check("idle_tick_valid", int'(bus.block_valid), 0);
        step(1, 1, 0);
        check("start_tick_valid", int'(bus.block_valid), 0);

        // Collision in GAP does nothing
        step(0, 0, 1);
        check("gap_coll_go", int'(bus.game_over), 0);

        // First spawn from seed A5
        step(0, 1, 0);
        check("spawn_x", int'(bus.block_x), 159);
        check("spawn_w", int'(bus.block_width), 6);
        check("spawn_h", int'(bus.block_height), 5);
        check("spawn_y", int'(bus.block_y), 95);
        check("spawn_valid", int'(bus.block_valid), 1);
        check("model_lfsr", m_lfsr, 'h4A);

        // start during SCROLL ignored
        step(1, 0, 0);
        check("scroll_start_x", int'(bus.block_x), 159);

        ticks(159);
        check("x_at_zero", int'(bus.block_x), 0);
        ticks(1);
        check("exit_valid", int'(bus.block_valid), 0);
        check("exit_score", int'(bus.score), 1);
        check("model_gap", m_gap, 28);
        ticks(28);
        check("gap_end_valid", int'(bus.block_valid), 0);
        ticks(1);
        check("respawn_valid", int'(bus.block_valid), 1);
        check("respawn_x", int'(bus.block_x), 159);

        // Speed ramp
        run_to_score(7);
        check("score7_speed", int'(bus.speed), 1);
        run_to_score(8);
        check("score8_speed", int'(bus.speed), 2);
        run_to_score(24);
        check("score24_speed", int'(bus.speed), 4);
        run_to_score(32);
        check("score32_speed", int'(bus.speed), 4);

        // start in GAP ignored
        step(1, 0, 0);
        check("gap_start_score", int'(bus.score), 32);

        // Collide at full speed, then restart
        run_to_scroll();
        ticks(3);
        step(0, 1, 1);
        check("halt1_go", int'(bus.game_over), 1);
        step(1, 0, 0);
        check("restart_score", int'(bus.score), 0);
        check("restart_speed", int'(bus.speed), 1);
        check("restart_valid", int'(bus.block_valid), 0);
        check("restart_go", int'(bus.game_over), 0);
        step(0, 1, 0);
        check("restart_w", int'(bus.block_width), 6);
        check("restart_h", int'(bus.block_height), 5);

        // Collision with tick at x=80: frozen
        ticks(79);
        check("pre_coll_x", int'(bus.block_x), 80);
        step(0, 1, 1);
        check("coll_x", int'(bus.block_x), 80);
        check("coll_go", int'(bus.game_over), 1);
        ticks(5);
        step(0, 0, 1);
        check("halt_x", int'(bus.block_x), 80);
        check("halt_valid", int'(bus.block_valid), 1);

        // Restart, scroll a bit, then async reset between edges
        step(1, 0, 0);
        ticks(10);
        check("pre_rst_x", int'(bus.block_x), 150);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_x", int'(bus.block_x), 0);
        check("async_valid", int'(bus.block_valid), 0);
        check("async_speed", int'(bus.speed), 1);
        check("async_score", int'(bus.score), 0);
        step(0, 1, 0);
        reset = 1'b0;
        ticks(5);
        check("post_rst_valid", int'(bus.block_valid), 0);
        check("post_rst_x", int'(bus.block_x), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
